// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

    // Two-state sequencer: normal issue, or EX held by a multi-cycle mul/div.
    typedef logic state_t;
    localparam state_t ST_RUN    = 1'b0;
    localparam state_t ST_MULDIV = 1'b1;

    // Default width of the saturating performance counters.
    localparam int CNT_WIDTH_DEF = 16;

endpackage : pipeline_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating event counter: counts up on inc_i and sticks at all-ones.
// Latency: one cycle from inc_i to the updated count.
// Backpressure: none; increments arriving while saturated are dropped.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: hold once every bit is set so the counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/pipeline_stall_controller.sv
// Merges load-use stall, branch flush, dmem wait and mul/div occupancy into register enables.
// Latency: zero cycles; controls decode from registered state plus current requests.
// Backpressure: dmem_busy freezes every pipeline register and defers any branch flush.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULDIV_LATENCY = 32,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hdu_stall,
    input  logic                 hdu_flush,
    input  logic                 dmem_busy,
    input  logic                 muldiv_start,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_write,
    output logic                 id_ex_flush,
    output logic                 ex_mem_write,
    output logic                 ex_mem_flush,
    output logic                 mem_wb_write,
    output logic                 muldiv_busy,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    // The start cycle counts as one EX cycle and the exit cycle as another, so the
    // down-counter is loaded with LATENCY-2 and the op leaves on the cycle it reads zero.
    localparam int CW = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY) : 1;
    localparam logic [CW-1:0] MD_RELOAD = CW'(MULDIV_LATENCY - 2);

    state_t        state_q, state_d;
    logic [CW-1:0] muldiv_cnt_q, muldiv_cnt_d;
    logic          pend_flush_q, pend_flush_d;
    logic          flush_applied;
    logic          stall_inc;

    // Priority decode: reset > dmem_busy > mul/div > load-use stall > flush.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_write  = 1'b1;
        ex_mem_flush  = 1'b0;
        mem_wb_write  = 1'b1;
        muldiv_busy   = 1'b0;
        flush_applied = 1'b0;
        state_d       = state_q;
        muldiv_cnt_d  = muldiv_cnt_q;
        pend_flush_d  = pend_flush_q;

        if (reset) begin
            // Hold every register and push bubbles into the front three stages.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_write  = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
            state_d       = ST_RUN;
            muldiv_cnt_d  = '0;
            pend_flush_d  = 1'b0;
        end else if (dmem_busy) begin
            // Whole pipeline freezes; mul/div progress is paused, branch flush remembered.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_write  = 1'b0;
            muldiv_busy   = (state_q == ST_MULDIV);
            pend_flush_d  = pend_flush_q | hdu_flush;
        end else if (state_q == ST_MULDIV) begin
            pend_flush_d  = pend_flush_q | hdu_flush;
            if (muldiv_cnt_q == '0) begin
                // Final EX cycle: result moves to EX/MEM, everything advances.
                state_d   = ST_RUN;
            end else begin
                // EX occupied: hold front end, drain bubbles behind the op.
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_flush  = 1'b1;
                muldiv_busy   = 1'b1;
                muldiv_cnt_d  = muldiv_cnt_q - CW'(1);
            end
        end else if (muldiv_start) begin
            // First EX cycle of a mul/div: same hold pattern as the busy cycles.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_flush  = 1'b1;
            state_d       = ST_MULDIV;
            muldiv_cnt_d  = MD_RELOAD;
            pend_flush_d  = pend_flush_q | hdu_flush;
        end else if (hdu_stall) begin
            // Load-use: hold PC and IF/ID, bubble into ID/EX; a branch flush waits.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_flush   = 1'b1;
            pend_flush_d  = pend_flush_q | hdu_flush;
        end else if (hdu_flush || pend_flush_q) begin
            // Squash the wrong-path fetch sitting in IF/ID.
            if_id_flush   = 1'b1;
            pend_flush_d  = 1'b0;
            flush_applied = 1'b1;
        end
    end

    // Sequencer state, mul/div down-counter and deferred-flush flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            muldiv_cnt_q <= '0;
            pend_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            muldiv_cnt_q <= muldiv_cnt_d;
            pend_flush_q <= pend_flush_d;
        end
    end

    // Any non-reset cycle where the PC holds is a lost issue slot.
    assign stall_inc = !reset && !pc_write;

    sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
        .clk_i (clk),
        .rst_i (reset),
        .inc_i (stall_inc),
        .cnt_o (stall_cycles)
    );

    sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
        .clk_i (clk),
        .rst_i (reset),
        .inc_i (flush_applied),
        .cnt_o (flush_count)
    );

endmodule : pipeline_stall_controller

// File: tb/tb_pipeline_stall_controller.sv
// Directed table-driven bench for the stall/flush sequencer (MULDIV_LATENCY=4, CNT_WIDTH=4).
// Latency: outputs checked mid-cycle, counters checked as seen before the next edge.
// Backpressure: dmem_busy sequences exercised from the vector table.
module tb_pipeline_stall_controller;

    localparam int LAT = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset, hdu_stall, hdu_flush, dmem_busy, muldiv_start;
    logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic          ex_mem_write, ex_mem_flush, mem_wb_write, muldiv_busy;
    logic [CW-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MULDIV_LATENCY(LAT), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .hdu_stall    (hdu_stall),
        .hdu_flush    (hdu_flush),
        .dmem_busy    (dmem_busy),
        .muldiv_start (muldiv_start),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_write  (id_ex_write),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_write (ex_mem_write),
        .ex_mem_flush (ex_mem_flush),
        .mem_wb_write (mem_wb_write),
        .muldiv_busy  (muldiv_busy),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    // Control bit order: pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, ex_mem_f, mem_wb_w, busy
    localparam logic [8:0] RST  = 9'b0_0_1_0_1_0_1_0_0;
    localparam logic [8:0] ALLW = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] STL  = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] FLS  = 9'b1_1_1_1_0_1_0_1_0;
    localparam logic [8:0] MDS  = 9'b0_0_0_0_0_1_1_1_0;
    localparam logic [8:0] MDB  = 9'b0_0_0_0_0_1_1_1_1;
    localparam logic [8:0] FRZ  = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] FRZM = 9'b0_0_0_0_0_0_0_0_1;

    typedef struct {
        logic          rst, stl, fls, bsy, st;
        logic [8:0]    ctl;
        logic          chk_cnt;
        logic [CW-1:0] sc, fc;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [8:0] ctl_now();
        return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                ex_mem_write, ex_mem_flush, mem_wb_write, muldiv_busy};
    endfunction

    task automatic add(input logic r, s, f, b, m, input logic [8:0] c,
                       input logic k, input int sc, input int fc);
        vec_t v;
        v.rst = r; v.stl = s; v.fls = f; v.bsy = b; v.st = m;
        v.ctl = c; v.chk_cnt = k; v.sc = CW'(sc); v.fc = CW'(fc);
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, s, f, b, m);
        reset = r; hdu_stall = s; hdu_flush = f; dmem_busy = b; muldiv_start = m;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s got %0h want %0h", name, got, want);
    endtask

    initial begin
        // reset, stall, flush, busy, start | expected controls | check counters | sc | fc
        add(1,0,0,0,0, RST,  0, 0, 0);   // 0  counters not yet defined
        add(1,0,0,0,0, RST,  1, 0, 0);   // 1
        add(0,0,0,0,0, ALLW, 1, 0, 0);   // 2
        add(0,1,0,0,0, STL,  1, 0, 0);   // 3  load-use stall
        add(0,0,0,0,0, ALLW, 1, 1, 0);   // 4
        add(0,0,1,0,0, FLS,  1, 1, 0);   // 5  branch flush
        add(0,0,0,0,0, ALLW, 1, 1, 1);   // 6
        add(0,0,0,0,1, MDS,  1, 1, 1);   // 7  mul/div start
        add(0,0,0,0,0, MDB,  1, 2, 1);   // 8
        add(0,0,0,0,0, MDB,  1, 3, 1);   // 9
        add(0,0,0,0,0, ALLW, 1, 4, 1);   // 10 exit cycle
        add(0,0,0,0,0, ALLW, 1, 4, 1);   // 11
        add(0,0,0,0,1, MDS,  1, 4, 1);   // 12 mul/div with dmem wait mid-op
        add(0,0,0,0,0, MDB,  1, 5, 1);   // 13
        for (int i = 0; i < 5; i++) add(0,0,0,1,0, FRZM, 1, 6 + i, 1);  // 14..18
        add(0,0,0,0,0, MDB,  1, 11, 1);  // 19
        add(0,0,0,0,0, ALLW, 1, 12, 1);  // 20 exits five cycles later
        add(0,0,0,0,0, ALLW, 1, 12, 1);  // 21
        add(0,0,1,1,0, FRZ,  1, 12, 1);  // 22 flush while busy: deferred
        add(0,0,0,1,0, FRZ,  1, 13, 1);  // 23
        add(0,0,0,0,0, FLS,  1, 14, 1);  // 24 pending flush applied
        add(0,0,0,0,0, ALLW, 1, 14, 2);  // 25 pending cleared
        add(1,0,0,0,0, RST,  1, 14, 2);  // 26
        add(0,0,0,0,0, ALLW, 1, 0, 0);   // 27
        add(0,0,0,0,1, MDS,  1, 0, 0);   // 28
        add(0,0,1,0,0, MDB,  1, 1, 0);   // 29 flush during mul/div: deferred
        add(0,0,0,0,0, MDB,  1, 2, 0);   // 30
        add(0,0,0,0,0, ALLW, 1, 3, 0);   // 31 exit cycle does not flush
        add(0,0,0,0,0, FLS,  1, 3, 0);   // 32 first plain RUN cycle flushes
        add(0,0,0,0,0, ALLW, 1, 3, 1);   // 33
        add(0,1,1,0,0, STL,  1, 3, 1);   // 34 stall beats flush
        add(0,0,0,0,0, FLS,  1, 4, 1);   // 35
        add(0,0,0,0,0, ALLW, 1, 4, 2);   // 36
        add(0,0,0,1,1, FRZ,  1, 4, 2);   // 37 start ignored while busy
        add(0,0,0,0,0, ALLW, 1, 5, 2);   // 38 still RUN
        add(0,1,0,0,1, MDS,  1, 5, 2);   // 39 mul/div beats load-use stall
        add(0,0,0,0,0, MDB,  1, 6, 2);   // 40
        add(0,0,0,0,0, MDB,  1, 7, 2);   // 41
        add(0,0,0,0,0, ALLW, 1, 8, 2);   // 42
        add(0,0,0,0,1, MDS,  1, 8, 2);   // 43
        add(0,0,0,0,0, MDB,  1, 9, 2);   // 44
        add(1,0,0,0,0, RST,  1, 10, 2);  // 45 reset mid-op
        add(0,0,0,0,0, ALLW, 1, 0, 0);   // 46 back in RUN, counters cleared

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].stl, vq[i].fls, vq[i].bsy, vq[i].st);
            #3;
            check_val($sformatf("v%0d_ctl", i), int'(ctl_now()), int'(vq[i].ctl));
            if (vq[i].chk_cnt) begin
                check_val($sformatf("v%0d_stall_cycles", i), int'(stall_cycles), int'(vq[i].sc));
                check_val($sformatf("v%0d_flush_count", i), int'(flush_count), int'(vq[i].fc));
            end
            next_cycle();
        end

        // Saturation: 20 stall cycles on a 4-bit counter must stop at 15.
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 0, 0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0);
        #3;
        check_val("stall_sat", int'(stall_cycles), 15);
        check_val("flush_before_sat", int'(flush_count), 0);
        next_cycle();

        // Saturation: 20 applied flushes must stop at 15.
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 0, 0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0);
        #3;
        check_val("flush_sat", int'(flush_count), 15);
        check_val("stall_hold", int'(stall_cycles), 15);
        check_val("idle_ctl", int'(ctl_now()), int'(ALLW));
        next_cycle();

        // Reset clears saturated counters on the next edge.
        drive(1, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        #3;
        check_val("stall_after_rst", int'(stall_cycles), 0);
        check_val("flush_after_rst", int'(flush_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipeline_stall_controller
